// File: rtl/sincos_cordic_pkg.sv
// Shared constants for the sin/cos vectoring CORDIC: arctangent table, gain
// correction constant, FSM states and the internal datapath width.
package sincos_cordic_pkg;

  localparam logic [15:0] K_GAIN = 16'd19898;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROT,
    ST_SCALE
  } state_t;

  // Two guard bits absorb the CORDIC gain and the negation of the most negative sample.
  function automatic int unsigned int_width(input int unsigned dw);
    return dw + 2;
  endfunction

  // atan(2^-i) in 16-bit turn units (65536 per revolution)
  function automatic logic [15:0] atan_lut(input logic [3:0] i);
    logic [15:0] a;
    case (i)
      4'd0:    a = 16'd8192;
      4'd1:    a = 16'd4836;
      4'd2:    a = 16'd2555;
      4'd3:    a = 16'd1297;
      4'd4:    a = 16'd651;
      4'd5:    a = 16'd326;
      4'd6:    a = 16'd163;
      4'd7:    a = 16'd81;
      4'd8:    a = 16'd41;
      4'd9:    a = 16'd20;
      4'd10:   a = 16'd10;
      4'd11:   a = 16'd5;
      4'd12:   a = 16'd3;
      4'd13:   a = 16'd1;
      4'd14:   a = 16'd1;
      default: a = 16'd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/sincos_angle_cordic_step.sv
// One vectoring-mode CORDIC micro-rotation; drives y toward zero while
// accumulating the rotated angle in z.
module cordic_vec_step
  import sincos_cordic_pkg::*;
#(
  parameter int unsigned IW = 18
) (
  input  logic signed [IW-1:0] x,
  input  logic signed [IW-1:0] y,
  input  logic        [15:0]   z,
  input  logic        [3:0]    i,
  output logic signed [IW-1:0] x_next,
  output logic signed [IW-1:0] y_next,
  output logic        [15:0]   z_next
);

  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;
  logic        [15:0]   at;

  always_comb begin
    x_sh = x >>> i;
    y_sh = y >>> i;
    at   = atan_lut(i);
    if (!y[IW-1]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + at;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - at;
    end
  end

endmodule

// File: rtl/sincos_angle_cordic.sv
// Iterative vectoring CORDIC: converts a filtered sin/cos pair into an angle
// (65536 LSB per turn) and a gain-corrected magnitude, one micro-rotation per clock.
module sincos_angle_cordic
  import sincos_cordic_pkg::*;
#(
  parameter int unsigned ITER = 16,
  parameter int unsigned DW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          data_en,
  input  logic [DW-1:0] sin_in,
  input  logic [DW-1:0] cos_in,
  output logic [DW-1:0] angle_out,
  output logic [DW-1:0] mag_out,
  output logic          angle_valid,
  output logic          busy,
  output logic [7:0]    drop_cnt
);

  localparam int unsigned IW = int_width(DW);
  localparam int unsigned PW = IW + 16;
  localparam logic [3:0]  LAST_ITER = 4'(ITER - 1);

  state_t state, state_nxt;

  logic signed [IW-1:0] x, y, x_step, y_step;
  logic signed [IW-1:0] sin_ext, cos_ext;
  logic        [15:0]   z, z_step;
  logic        [3:0]    iter;
  logic                 zero_in;
  logic                 capture;
  logic signed [PW-1:0] prod, scaled;
  logic        [DW-1:0] mag_sat;

  cordic_vec_step #(.IW(IW)) u_step (
    .x      (x),
    .y      (y),
    .z      (z),
    .i      (iter),
    .x_next (x_step),
    .y_next (y_step),
    .z_next (z_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (data_en) state_nxt = ST_ROT;
      ST_ROT:   if (iter == LAST_ITER) state_nxt = ST_SCALE;
      ST_SCALE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    capture = (state == ST_IDLE) && data_en;
  end

  always_comb begin
    sin_ext = IW'($signed(sin_in));
    cos_ext = IW'($signed(cos_in));
    prod    = PW'(x) * PW'($signed({1'b0, K_GAIN}));
    scaled  = prod >>> 15;
    if (scaled < 0)                mag_sat = '0;
    else if (|scaled[PW-1:DW])     mag_sat = '1;
    else                           mag_sat = scaled[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      z           <= '0;
      iter        <= '0;
      zero_in     <= 1'b0;
      angle_out   <= '0;
      mag_out     <= '0;
      angle_valid <= 1'b0;
    end else begin
      angle_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (capture) begin
            // Left half-plane is folded by 180 deg so the rotations only cover +/-99.9 deg.
            if (cos_ext < 0) begin
              x <= -cos_ext;
              y <= -sin_ext;
              z <= 16'h8000;
            end else begin
              x <= cos_ext;
              y <= sin_ext;
              z <= '0;
            end
            iter    <= '0;
            zero_in <= (sin_in == '0) && (cos_in == '0);
          end
        end
        ST_ROT: begin
          x    <= x_step;
          y    <= y_step;
          z    <= z_step;
          iter <= iter + 4'd1;
        end
        ST_SCALE: begin
          // A zero vector would otherwise report the summed atan table as its angle.
          angle_out   <= zero_in ? '0 : DW'(z);
          mag_out     <= mag_sat;
          angle_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (data_en && busy && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'd1;
  end

endmodule
